// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, funct3 codes and legality check for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_legal(input logic [2:0] f3, input logic is_store);
        return is_store ? (f3 inside {F3_B, F3_H, F3_W})
                        : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores and lane select plus extension for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign,
    output logic [31:0] o_rdata
);

    logic        w_half;
    logic        w_word;
    logic [15:0] w_sh;

    always_comb begin
        w_half     = i_funct3[1:0] == 2'b01;
        w_word     = i_funct3[1:0] == 2'b10;
        w_sh       = 16'(i_rdata >> {i_off, 3'b000});
        o_misalign = (w_half & i_off[0]) | (w_word & (|i_off));
        o_be       = w_word ? 4'b1111 : w_half ? 4'b0011 << i_off : 4'b0001 << i_off;
        o_wdata    = w_word ? i_wdata : w_half ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}};
        o_rdata    = i_funct3 == F3_B  ? {{24{w_sh[7]}}, w_sh[7:0]} :
                     i_funct3 == F3_H  ? {{16{w_sh[15]}}, w_sh} :
                     i_funct3 == F3_W  ? i_rdata :
                     i_funct3 == F3_BU ? {24'b0, w_sh[7:0]} :
                     i_funct3 == F3_HU ? {16'b0, w_sh} : 32'b0;
    end

endmodule

// File: rtl/lsu.sv
// lsu: memory-stage load/store unit driving a request/grant/response data bus,
// stalling the pipeline until the access completes, errors or times out.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_rd_m,
    input  logic          mem_wr_m,
    input  logic [2:0]    funct3_m,
    input  logic [AW-1:0] addr_m,
    input  logic [31:0]   wdata_m,
    output logic [31:0]   rdata_m,
    output logic          stall_m,
    output logic          err_m,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [3:0]    bus_be,
    output logic [31:0]   bus_wdata,
    input  logic          bus_gnt,
    input  logic          bus_rvalid,
    input  logic [31:0]   bus_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        r_state, w_next;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_off;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata, r_data;
    logic [2:0]    r_f3;
    logic          r_we, r_err;
    logic [CW-1:0] r_cnt;
    logic          w_idle, w_acc, w_bad, w_to, w_mis, w_req;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_rext;
    logic [2:0]    w_f3;
    logic [1:0]    w_off;

    assign w_idle = r_state == IDLE;
    assign w_acc  = mem_rd_m | mem_wr_m;
    assign w_f3   = w_idle ? funct3_m : r_f3;
    assign w_off  = w_idle ? addr_m[1:0] : r_off;
    assign w_bad  = !is_legal(funct3_m, mem_wr_m) || w_mis;
    // >= so a grant on the last REQ cycle cannot skip past the limit in WAIT
    assign w_to   = r_cnt >= CW'(TIMEOUT - 1);
    assign w_req  = r_state == REQ;

    lsu_align u_align (
        .i_funct3   (w_f3),
        .i_off      (w_off),
        .i_wdata    (wdata_m),
        .i_rdata    (bus_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_misalign (w_mis),
        .o_rdata    (w_rext)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_acc ? (w_bad ? DONE : REQ) : IDLE;
            REQ:     w_next = bus_gnt ? (r_we ? DONE : WAIT) : w_to ? DONE : REQ;
            WAIT:    w_next = (bus_rvalid || w_to) ? DONE : WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_off   <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_data  <= '0;
            r_f3    <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_acc) begin
                        r_err   <= w_bad;
                        r_data  <= '0;
                        r_addr  <= {addr_m[AW-1:2], 2'b00};
                        r_off   <= addr_m[1:0];
                        r_f3    <= funct3_m;
                        r_we    <= mem_wr_m;
                        r_be    <= mem_wr_m ? w_be : 4'b0000;
                        r_wdata <= mem_wr_m ? w_wdata : 32'b0;
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!bus_gnt && w_to) r_err <= 1'b1;
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus_rvalid) r_data <= w_rext;
                    else if (w_to) r_err <= 1'b1;
                end
                default: begin
                    r_cnt <= '0;
                    r_err <= 1'b0;
                end
            endcase
        end
    end

    assign stall_m   = rst & w_acc & (r_state != DONE);
    assign err_m     = (r_state == DONE) & r_err;
    assign rdata_m   = (r_state == DONE) ? r_data : 32'b0;
    assign bus_req   = w_req;
    assign bus_we    = w_req & r_we;
    assign bus_addr  = w_req ? r_addr : '0;
    assign bus_be    = w_req ? r_be : 4'b0000;
    assign bus_wdata = w_req ? r_wdata : 32'b0;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized scoreboard bench for lsu; the driver plays the pipeline and the bus,
// a negedge monitor compares DUT responses against a reference model's expectations.
module tb_lsu;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst, mem_rd_m, mem_wr_m;
    logic [2:0]  funct3_m;
    logic [31:0] addr_m, wdata_m, rdata_m;
    logic        stall_m, err_m, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stalls;
        bit          chk;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    exp_t        exp_q[$];
    bus_t        bus_q[$];
    exp_t        e;
    bus_t        b;
    int          tests = 0;
    int          fails = 0;
    int          hung = 0;
    int          st_cnt = 0;
    bit          fin = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_gnt = 1'b0;
    logic [68:0] prev_bus = '0;

    lsu #(.TIMEOUT(TO), .AW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_rd_m   (mem_rd_m),
        .mem_wr_m   (mem_wr_m),
        .funct3_m   (funct3_m),
        .addr_m     (addr_m),
        .wdata_m    (wdata_m),
        .rdata_m    (rdata_m),
        .stall_m    (stall_m),
        .err_m      (err_m),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] sh, bt, hw;
        sh = w >> (8 * off);
        bt = sh & 32'hFF;
        hw = sh & 32'hFFFF;
        case (f3)
            3'd0: return bt >= 128 ? bt + 32'hFFFFFF00 : bt;
            3'd1: return hw >= 32768 ? hw + 32'hFFFF0000 : hw;
            3'd2: return w;
            3'd4: return bt;
            3'd5: return hw;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_outputs", {stall_m, err_m, rdata_m, bus_req, bus_we, bus_addr, bus_be, bus_wdata}, 0);
            st_cnt = 0;
        end else if (mem_rd_m || mem_wr_m) begin
            if (stall_m) st_cnt++;
            else begin
                if (exp_q.size() == 0) chk("done_without_access", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("err_m", err_m, e.err);
                    chk("stall_cycles", st_cnt, e.stalls);
                    if (e.chk) chk("rdata_m", rdata_m, e.rdata);
                end
                st_cnt = 0;
            end
        end else chk("idle_outputs", {stall_m, err_m, bus_req, rdata_m}, 0);
        if (rst && bus_req) begin
            if (prev_req && !prev_gnt) chk("req_stable", {bus_addr, bus_be, bus_we, bus_wdata}, prev_bus);
            if (bus_gnt) begin
                if (bus_q.size() == 0) chk("unexpected_grant", 1, 0);
                else begin
                    b = bus_q.pop_front();
                    chk("bus_addr", bus_addr, b.addr);
                    chk("bus_be", bus_be, b.be);
                    chk("bus_we", bus_we, b.we);
                    if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
                end
            end
        end
        prev_req = rst && bus_req;
        prev_gnt = bus_gnt;
        prev_bus = {bus_addr, bus_be, bus_we, bus_wdata};
        if (fin) begin
            chk("hung_accesses", hung, 0);
            chk("pending_responses", exp_q.size(), 0);
            chk("pending_bus", bus_q.size(), 0);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] word, input int gdly, input int rdly,
                          input bit never, input int rst_at);
        bit          legal, bad, to, done, req_s, gd;
        int unsigned size;
        int          lat, req_cnt, since;
        exp_t        xe;
        bus_t        xb;
        logic [1:0]  off;
        off   = addr[1:0];
        legal = wr ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        size  = 1 << f3[1:0];
        bad   = !legal || (addr % size) != 0;
        lat   = wr ? gdly + 1 : (never ? 1000 : gdly + 1 + rdly);
        to    = !bad && lat > TO;
        xe.err    = bad || to;
        xe.stalls = bad ? 1 : to ? TO + 1 : 1 + lat;
        xe.chk    = rd;
        xe.rdata  = (bad || to) ? 32'h0 : ref_load(word, off, f3);
        if (rst_at < 0) exp_q.push_back(xe);
        if (!bad && gdly < TO) begin
            xb.addr  = addr & ~32'h3;
            xb.we    = wr;
            xb.be    = !wr ? 4'h0 : f3 == 0 ? 4'(1 << off) : f3 == 1 ? 4'(3 << off) : 4'hF;
            xb.wdata = f3 == 0 ? (wdata & 32'hFF) * 32'h01010101 :
                       f3 == 1 ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
            bus_q.push_back(xb);
        end
        mem_rd_m = rd;
        mem_wr_m = wr;
        funct3_m = f3;
        addr_m   = addr;
        wdata_m  = wdata;
        req_cnt  = 0;
        since    = 0;
        gd       = 1'b0;
        done     = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            bus_gnt    = bus_req && req_cnt >= gdly;
            bus_rvalid = gd && !never && since == rdly;
            bus_rdata  = bus_rvalid ? word : $urandom;
            @(negedge clk);
            done  = !stall_m;
            req_s = bus_req;
            @(posedge clk);
            #1;
            if (gd) since++;
            if (req_s && bus_gnt) begin
                gd    = 1'b1;
                since = 1;
            end else if (req_s) req_cnt++;
            if (c == rst_at) begin
                #1 rst = 1'b0;
                @(negedge clk);
                @(posedge clk);
                #1;
                mem_rd_m   = 1'b0;
                mem_wr_m   = 1'b0;
                bus_gnt    = 1'b0;
                rst        = 1'b1;
                bus_rvalid = 1'b1;
                bus_rdata  = $urandom;
                @(posedge clk);
                #1 bus_rvalid = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            hung++;
            $display("FAIL access_bound: got no DONE expected DONE within 40 cycles");
        end
        mem_rd_m   = 1'b0;
        mem_wr_m   = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        if ($urandom_range(1) == 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic        rd;
        logic [2:0]  f3;
        int          gdly, rdly;
        rst        = 1'b0;
        mem_rd_m   = 1'b0;
        mem_wr_m   = 1'b0;
        funct3_m   = 3'b0;
        addr_m     = 32'h0;
        wdata_m    = 32'h0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1, 1'b0, -1);
        access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 0, 3, 1'b0, -1);
        access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 0, 3, 1'b0, -1);
        access(1'b0, 1'b1, 3'b001, 32'h002, 32'h0000ABCD, 32'h0, 0, 1, 1'b0, -1);
        access(1'b1, 1'b0, 3'b001, 32'h001, 32'h0, 32'h12345678, 0, 1, 1'b0, -1);
        access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 3, 1, 1'b0, -1);
        access(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'h0, 0, 1, 1'b1, -1);
        access(1'b1, 1'b0, 3'b011, 32'h48, 32'h0, 32'h11111111, 0, 1, 1'b0, -1);
        access(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 32'h55AA55AA, 0, 10, 1'b0, 3);
        access(1'b1, 1'b0, 3'b010, 32'h84, 32'h0, 32'h87654321, 0, 2, 1'b0, -1);
        access(1'b1, 1'b0, 3'b010, 32'h88, 32'h0, 32'h0BADCAFE, 0, 15, 1'b0, -1);
        access(1'b1, 1'b0, 3'b010, 32'h8C, 32'h0, 32'h0BADCAFE, 0, 16, 1'b0, -1);
        access(1'b0, 1'b1, 3'b000, 32'h91, 32'h000000A5, 32'h0, 16, 1, 1'b0, -1);
        for (int i = 0; i < 300; i++) begin
            rd   = $urandom_range(1) == 1;
            f3   = $urandom_range(3) == 0 ? 3'($urandom_range(7)) : 3'($urandom_range(2));
            if (rd && f3 == 3'd0 && $urandom_range(1) == 1) f3 = 3'd4;
            if (rd && f3 == 3'd1 && $urandom_range(1) == 1) f3 = 3'd5;
            gdly = $urandom_range(15) == 0 ? $urandom_range(17, 16) : $urandom_range(3);
            rdly = $urandom_range(15) == 0 ? $urandom_range(16, 13) : $urandom_range(4, 1);
            access(rd, !rd, f3, $urandom, $urandom, $urandom, gdly, rdly, $urandom_range(19) == 0, -1);
        end
        fin = 1'b1;
    end

endmodule
